// File: rtl/uart_bus_bridge_pkg.sv
// Shared types and constants for the UART-to-peripheral-bus debug bridge.
package uart_bus_bridge_pkg;

  // Bridge control states.
  typedef enum logic [2:0] {
    CMD   = 3'd0,
    WDATA = 3'd1,
    WR    = 3'd2,
    RD    = 3'd3,
    WAIT  = 3'd4,
    RESP  = 3'd5
  } bridgeState_t;

  localparam int CMD_WRITE_BIT  = 7;
  localparam int BYTES_PER_WORD = 4;

  localparam logic [7:0] DEFAULT_ACK_BYTE = 8'hA5;
  localparam logic [7:0] DEFAULT_ERR_BYTE = 8'hEE;

  // Byte index of the last byte of a word (also the serializer count for a word).
  localparam logic [1:0] WORD_LAST_COUNT = 2'(BYTES_PER_WORD - 1);

  // True when a command byte requests a bus write.
  function automatic logic isWriteCmd(input logic [7:0] cmd);
    return cmd[CMD_WRITE_BIT];
  endfunction

endpackage

// File: rtl/uart_bus_bridge_resp_shifter.sv
// Response serializer: loads a word (4 bytes) or a single status byte and
// presents it LSB first on a valid/ready byte handshake.
module bridge_resp_shifter
  import uart_bus_bridge_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] loadData,
  input  logic [1:0]  loadCount,
  output logic [7:0]  outByte,
  output logic        outValid,
  input  logic        outReady,
  output logic        done
);

  logic [31:0] shiftR;
  logic [1:0]  countR;
  logic        validR;
  logic        accept;

  assign accept   = validR & outReady;
  assign outByte  = shiftR[7:0];
  assign outValid = validR;
  // Final byte of the current response is being taken this cycle.
  assign done     = accept & (countR == 2'd0);

  // Load, shift on every accepted byte, drop valid after the last one.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shiftR <= 32'h0000_0000;
      countR <= 2'd0;
      validR <= 1'b0;
    end else if (load) begin
      shiftR <= loadData;
      countR <= loadCount;
      validR <= 1'b1;
    end else if (accept) begin
      shiftR <= {8'h00, shiftR[31:8]};
      if (countR == 2'd0) begin
        countR <= 2'd0;
        validR <= 1'b0;
      end else begin
        countR <= countR - 2'd1;
        validR <= 1'b1;
      end
    end else begin
      shiftR <= shiftR;
      countR <= countR;
      validR <= validR;
    end
  end

endmodule

// File: rtl/uart_bus_bridge.sv
// Debug bus initiator: turns UART command bytes into single-cycle peripheral
// bus reads/writes and returns an ACK, the read word, or an error byte.
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int         ADDR_W   = 2,
  parameter int         TIMEOUT  = 16,
  parameter logic [7:0] ACK_BYTE = DEFAULT_ACK_BYTE,
  parameter logic [7:0] ERR_BYTE = DEFAULT_ERR_BYTE
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_byte,
  input  logic              rx_byte_valid,
  output logic              rx_byte_ready,
  output logic [7:0]        tx_byte,
  output logic              tx_byte_valid,
  input  logic              tx_byte_ready,
  output logic              bus_read,
  output logic              bus_write,
  output logic [ADDR_W-1:0] bus_address,
  output logic [31:0]       bus_data_out,
  input  logic              bus_read_valid,
  input  logic [31:0]       bus_data_in
);

  localparam int            TW           = $clog2(TIMEOUT) + 1;
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT - 1);
  localparam logic [TW-1:0] TIMEOUT_ONE  = TW'(1);

  bridgeState_t      stateR;
  bridgeState_t      stateNext;
  logic              rxReadyR;
  logic              rxAccept;
  logic [1:0]        byteCountR;
  logic              lastDataByte;
  logic [31:0]       dataR;
  logic [ADDR_W-1:0] addrR;
  logic [31:0]       busDataOutR;
  logic              busReadR;
  logic              busWriteR;
  logic [TW-1:0]     timeoutCountR;
  logic              timeoutExpired;

  logic              readStrobeNext;
  logic              writeStrobeNext;
  logic              loadShifter;
  logic [31:0]       loadData;
  logic [1:0]        loadCount;
  logic              respDone;

  assign rxAccept       = rx_byte_valid & rxReadyR;
  assign lastDataByte   = (byteCountR == WORD_LAST_COUNT);
  assign timeoutExpired = (timeoutCountR == TIMEOUT_LAST);

  assign rx_byte_ready  = rxReadyR;
  assign bus_read       = busReadR;
  assign bus_write      = busWriteR;
  assign bus_address    = addrR;
  assign bus_data_out   = busDataOutR;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stateR <= CMD;
    end else begin
      stateR <= stateNext;
    end
  end

  // Next-state, bus strobe requests and response-serializer loads.
  always_comb begin
    stateNext       = stateR;
    readStrobeNext  = 1'b0;
    writeStrobeNext = 1'b0;
    loadShifter     = 1'b0;
    loadData        = 32'h0000_0000;
    loadCount       = 2'd0;
    case (stateR)
      CMD: begin
        if (rxAccept) begin
          if (isWriteCmd(rx_byte)) begin
            stateNext = WDATA;
          end else begin
            stateNext      = RD;
            readStrobeNext = 1'b1;
          end
        end else begin
          stateNext = CMD;
        end
      end
      WDATA: begin
        // Strobe is raised on the same edge that takes the 4th data byte.
        if (rxAccept && lastDataByte) begin
          stateNext       = WR;
          writeStrobeNext = 1'b1;
        end else begin
          stateNext = WDATA;
        end
      end
      WR: begin
        loadShifter = 1'b1;
        loadData    = {24'h00_0000, ACK_BYTE};
        loadCount   = 2'd0;
        stateNext   = RESP;
      end
      RD: begin
        stateNext = WAIT;
      end
      WAIT: begin
        // Read data takes priority over a timeout in the same cycle.
        if (bus_read_valid) begin
          loadShifter = 1'b1;
          loadData    = bus_data_in;
          loadCount   = WORD_LAST_COUNT;
          stateNext   = RESP;
        end else if (timeoutExpired) begin
          loadShifter = 1'b1;
          loadData    = {24'h00_0000, ERR_BYTE};
          loadCount   = 2'd0;
          stateNext   = RESP;
        end else begin
          stateNext = WAIT;
        end
      end
      RESP: begin
        if (respDone) begin
          stateNext = CMD;
        end else begin
          stateNext = RESP;
        end
      end
      default: begin
        stateNext = CMD;
      end
    endcase
  end

  // Registered handshake ready and single-cycle bus strobes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rxReadyR  <= 1'b0;
      busReadR  <= 1'b0;
      busWriteR <= 1'b0;
    end else begin
      rxReadyR  <= (stateNext == CMD) || (stateNext == WDATA);
      busReadR  <= readStrobeNext;
      busWriteR <= writeStrobeNext;
    end
  end

  // Command address capture; bus_address holds between transactions.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      addrR <= '0;
    end else if ((stateR == CMD) && rxAccept) begin
      addrR <= rx_byte[ADDR_W-1:0];
    end else begin
      addrR <= addrR;
    end
  end

  // Write-data byte counter: restarts at each command, counts accepted data bytes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      byteCountR <= 2'd0;
    end else if ((stateR == CMD) && rxAccept) begin
      byteCountR <= 2'd0;
    end else if ((stateR == WDATA) && rxAccept) begin
      byteCountR <= byteCountR + 2'd1;
    end else begin
      byteCountR <= byteCountR;
    end
  end

  // Little-endian data assembly; bus_data_out only changes when the word completes.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dataR       <= 32'h0000_0000;
      busDataOutR <= 32'h0000_0000;
    end else if ((stateR == WDATA) && rxAccept) begin
      dataR <= {rx_byte, dataR[31:8]};
      if (lastDataByte) begin
        busDataOutR <= {rx_byte, dataR[31:8]};
      end else begin
        busDataOutR <= busDataOutR;
      end
    end else begin
      dataR       <= dataR;
      busDataOutR <= busDataOutR;
    end
  end

  // Read timeout counter: cleared while strobing, saturating count while waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      timeoutCountR <= '0;
    end else if (stateR == RD) begin
      timeoutCountR <= '0;
    end else if ((stateR == WAIT) && !timeoutExpired) begin
      timeoutCountR <= timeoutCountR + TIMEOUT_ONE;
    end else begin
      timeoutCountR <= timeoutCountR;
    end
  end

  bridge_resp_shifter uRespShifter (
    .clk       (clk),
    .reset     (reset),
    .load      (loadShifter),
    .loadData  (loadData),
    .loadCount (loadCount),
    .outByte   (tx_byte),
    .outValid  (tx_byte_valid),
    .outReady  (tx_byte_ready),
    .done      (respDone)
  );

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Self-checking bench for uart_bus_bridge: directed scenarios plus randomized
// transactions compared against a transaction-level response model.
module tb_uart_bus_bridge;

  localparam int         ADDR_W  = 2;
  localparam int         TIMEOUT = 16;
  localparam logic [7:0] ACK     = 8'hA5;
  localparam logic [7:0] ERR     = 8'hEE;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [7:0]        rx_byte = 8'h00;
  logic              rx_byte_valid = 1'b0;
  logic              rx_byte_ready;
  logic [7:0]        tx_byte;
  logic              tx_byte_valid;
  logic              tx_byte_ready = 1'b0;
  logic              bus_read;
  logic              bus_write;
  logic [ADDR_W-1:0] bus_address;
  logic [31:0]       bus_data_out;
  logic              bus_read_valid = 1'b0;
  logic [31:0]       bus_data_in = 32'h0;

  always #5 clk = ~clk;

  uart_bus_bridge #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT), .ACK_BYTE(ACK), .ERR_BYTE(ERR)) dut (
    .clk(clk), .reset(reset),
    .rx_byte(rx_byte), .rx_byte_valid(rx_byte_valid), .rx_byte_ready(rx_byte_ready),
    .tx_byte(tx_byte), .tx_byte_valid(tx_byte_valid), .tx_byte_ready(tx_byte_ready),
    .bus_read(bus_read), .bus_write(bus_write), .bus_address(bus_address),
    .bus_data_out(bus_data_out), .bus_read_valid(bus_read_valid), .bus_data_in(bus_data_in)
  );

  int testsRun = 0;
  int failCount = 0;

  // Slave model: answers a read strobe after slaveDelay cycles (0 = never).
  int          slaveDelay = 0;
  logic [31:0] slaveData = 32'h0;
  int          pending = 0;

  initial begin
    forever begin
      @(negedge clk);
      bus_read_valid = 1'b0;
      if (reset) begin
        pending = 0;
      end else begin
        if (pending > 0) begin
          pending--;
          if (pending == 0) begin
            bus_read_valid = 1'b1;
            bus_data_in    = slaveData;
          end
        end
        if (bus_read === 1'b1 && slaveDelay > 0) pending = slaveDelay;
      end
    end
  end

  // Bus/handshake monitor.
  int cyc = 0, writeCount = 0, readCount = 0, bothHigh = 0, readWide = 0, writeWide = 0;
  int txRiseCount = 0, lastWriteCycle = 0, lastReadCycle = 0, lastTxRiseCycle = 0;
  logic prevRead = 1'b0, prevWrite = 1'b0, prevTxValid = 1'b0;
  logic [ADDR_W-1:0] lastWriteAddr = '0, lastReadAddr = '0;
  logic [31:0] lastWriteData = 32'h0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (bus_read === 1'b1) begin
        readCount++; lastReadCycle = cyc; lastReadAddr = bus_address;
        if (prevRead) readWide++;
      end
      if (bus_write === 1'b1) begin
        writeCount++; lastWriteCycle = cyc; lastWriteAddr = bus_address; lastWriteData = bus_data_out;
        if (prevWrite) writeWide++;
      end
      if (bus_read === 1'b1 && bus_write === 1'b1) bothHigh++;
      if (tx_byte_valid === 1'b1 && !prevTxValid) begin
        txRiseCount++; lastTxRiseCycle = cyc;
      end
      prevRead = (bus_read === 1'b1);
      prevWrite = (bus_write === 1'b1);
      prevTxValid = (tx_byte_valid === 1'b1);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", testsRun);
    $fatal(1, "watchdog expired");
  end

  // Reference model: expected response of one command, from the command rules only.
  logic [31:0] expWord;
  int          expCount;
  logic [31:0] gotWord;
  int          gotCount;

  task automatic modelResp(input logic [7:0] cmd, input int delay, input logic [31:0] rdata);
    if (cmd[7]) begin
      expWord = {24'h0, ACK}; expCount = 1;
    end else if (delay >= 1 && delay <= TIMEOUT) begin
      expWord = rdata; expCount = 4;
    end else begin
      expWord = {24'h0, ERR}; expCount = 1;
    end
  endtask

  task automatic sendByte(input logic [7:0] b);
    int n;
    n = 0;
    rx_byte = b; rx_byte_valid = 1'b1;
    while (rx_byte_ready !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    if (rx_byte_ready !== 1'b1) begin
      testsRun++; failCount++;
      $display("FAIL send_timeout: rx_byte_ready=%b required 1 for byte %h", rx_byte_ready, b);
      rx_byte_valid = 1'b0;
      return;
    end
    @(negedge clk);
    rx_byte_valid = 1'b0;
  endtask

  task automatic recvByte(input int stall, output logic [7:0] b, output bit ok);
    int n;
    logic [7:0] held;
    n = 0; ok = 1'b0; b = 8'h00;
    while (tx_byte_valid !== 1'b1 && n < 200) begin
      @(negedge clk); n++;
    end
    if (tx_byte_valid !== 1'b1) begin
      testsRun++; failCount++;
      $display("FAIL recv_timeout: tx_byte_valid=%b required 1", tx_byte_valid);
      return;
    end
    held = tx_byte;
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      testsRun++;
      if (tx_byte !== held || tx_byte_valid !== 1'b1) begin
        failCount++;
        $display("FAIL tx_stable: tx_byte=%h valid=%b required %h valid 1", tx_byte, tx_byte_valid, held);
      end
      testsRun++;
      if (rx_byte_ready !== 1'b0) begin
        failCount++;
        $display("FAIL rx_ready_in_resp: rx_byte_ready=%b required 0", rx_byte_ready);
      end
    end
    b = tx_byte;
    tx_byte_ready = 1'b1;
    @(negedge clk);
    tx_byte_ready = 1'b0;
    ok = 1'b1;
  endtask

  // Send a command (plus write data) and collect expCount response bytes.
  task automatic runTxn(input logic [7:0] cmd, input logic [31:0] wdata, input int stall);
    logic [7:0] b;
    bit ok;
    gotWord = 32'h0; gotCount = 0;
    sendByte(cmd);
    if (cmd[7]) begin
      for (int i = 0; i < 4; i++) sendByte(wdata[8*i +: 8]);
    end
    for (int i = 0; i < expCount; i++) begin
      recvByte(stall, b, ok);
      if (!ok) break;
      gotWord[8*i +: 8] = b;
      gotCount++;
    end
  endtask

  task automatic test_reset();
    testsRun++;
    if ({rx_byte_ready, tx_byte_valid, bus_read, bus_write} !== 4'b0000) begin
      failCount++;
      $display("FAIL reset_strobes: ready/txv/rd/wr=%b required 0000", {rx_byte_ready, tx_byte_valid, bus_read, bus_write});
    end
    testsRun++;
    if ({tx_byte, bus_address, bus_data_out} !== '0) begin
      failCount++;
      $display("FAIL reset_data: tx_byte=%h addr=%h data=%h required all 0", tx_byte, bus_address, bus_data_out);
    end
    reset = 1'b0;
    @(negedge clk);
    testsRun++;
    if (rx_byte_ready !== 1'b1 || tx_byte_valid !== 1'b0) begin
      failCount++;
      $display("FAIL reset_idle: rx_ready=%b tx_valid=%b required 1 0", rx_byte_ready, tx_byte_valid);
    end
  endtask

  task automatic test_write();
    int w0, r0;
    w0 = writeCount; r0 = readCount;
    slaveDelay = 0;
    modelResp(8'h83, 0, 32'h0);
    runTxn(8'h83, 32'h1234_5678, 0);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord) begin
      failCount++;
      $display("FAIL write_resp: got %0d bytes %h required %0d bytes %h", gotCount, gotWord, expCount, expWord);
    end
    testsRun++;
    if (writeCount - w0 != 1 || readCount != r0) begin
      failCount++;
      $display("FAIL write_pulses: writes=%0d reads=%0d required 1 0", writeCount - w0, readCount - r0);
    end
    testsRun++;
    if (lastWriteAddr !== 2'd3 || lastWriteData !== 32'h1234_5678) begin
      failCount++;
      $display("FAIL write_bus: addr=%h data=%h required 3 12345678", lastWriteAddr, lastWriteData);
    end
    testsRun++;
    if (lastTxRiseCycle - lastWriteCycle != 1) begin
      failCount++;
      $display("FAIL write_latency: %0d cycles required 1", lastTxRiseCycle - lastWriteCycle);
    end
    testsRun++;
    if (tx_byte_valid !== 1'b0 || bus_data_out !== 32'h1234_5678 || bus_address !== 2'd3) begin
      failCount++;
      $display("FAIL write_hold: txv=%b data=%h addr=%h required 0 12345678 3", tx_byte_valid, bus_data_out, bus_address);
    end
  endtask

  task automatic test_read();
    int r0;
    r0 = readCount;
    slaveDelay = 2; slaveData = 32'hDEAD_BEEF;
    modelResp(8'h02, 2, 32'hDEAD_BEEF);
    runTxn(8'h02, 32'h0, 0);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord) begin
      failCount++;
      $display("FAIL read_resp: got %0d bytes %h required %0d bytes %h", gotCount, gotWord, expCount, expWord);
    end
    testsRun++;
    if (readCount - r0 != 1 || lastReadAddr !== 2'd2) begin
      failCount++;
      $display("FAIL read_pulse: reads=%0d addr=%h required 1 2", readCount - r0, lastReadAddr);
    end
    testsRun++;
    if (lastTxRiseCycle - lastReadCycle != 3) begin
      failCount++;
      $display("FAIL read_latency: %0d cycles required 3", lastTxRiseCycle - lastReadCycle);
    end
  endtask

  task automatic test_timeout();
    int late;
    late = 0;
    slaveDelay = TIMEOUT + 5; slaveData = 32'h55AA_55AA;
    modelResp(8'h01, TIMEOUT + 5, 32'h55AA_55AA);
    runTxn(8'h01, 32'h0, 0);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord) begin
      failCount++;
      $display("FAIL timeout_resp: got %0d bytes %h required %0d bytes %h", gotCount, gotWord, expCount, expWord);
    end
    testsRun++;
    if (lastTxRiseCycle - lastReadCycle != TIMEOUT + 1) begin
      failCount++;
      $display("FAIL timeout_latency: %0d cycles required %0d", lastTxRiseCycle - lastReadCycle, TIMEOUT + 1);
    end
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (tx_byte_valid === 1'b1) late++;
    end
    testsRun++;
    if (late != 0) begin
      failCount++;
      $display("FAIL late_ignored: tx_valid cycles=%0d required 0", late);
    end
    slaveDelay = 2; slaveData = 32'hCAFE_F00D;
    modelResp(8'h03, 2, 32'hCAFE_F00D);
    runTxn(8'h03, 32'h0, 0);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord || lastReadAddr !== 2'd3) begin
      failCount++;
      $display("FAIL after_timeout: got %0d bytes %h addr %h required %0d bytes %h addr 3", gotCount, gotWord, lastReadAddr, expCount, expWord);
    end
  endtask

  task automatic test_backpressure();
    slaveDelay = 2; slaveData = 32'h8421_C3E7;
    modelResp(8'h00, 2, 32'h8421_C3E7);
    runTxn(8'h00, 32'h0, 10);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord) begin
      failCount++;
      $display("FAIL backpressure_resp: got %0d bytes %h required %0d bytes %h", gotCount, gotWord, expCount, expWord);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0, t0;
    w0 = writeCount; t0 = txRiseCount;
    sendByte(8'h82); sendByte(8'h11); sendByte(8'h22);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    testsRun++;
    if (writeCount != w0 || txRiseCount != t0) begin
      failCount++;
      $display("FAIL reset_abort: writes=%0d tx_rises=%0d required 0 0", writeCount - w0, txRiseCount - t0);
    end
    modelResp(8'h81, 0, 32'h0);
    runTxn(8'h81, 32'h0000_00FF, 0);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord || writeCount - w0 != 1) begin
      failCount++;
      $display("FAIL reset_recover_resp: got %0d bytes %h writes %0d required %0d bytes %h writes 1", gotCount, gotWord, writeCount - w0, expCount, expWord);
    end
    testsRun++;
    if (lastWriteAddr !== 2'd1 || lastWriteData !== 32'h0000_00FF) begin
      failCount++;
      $display("FAIL reset_recover_bus: addr=%h data=%h required 1 000000ff", lastWriteAddr, lastWriteData);
    end
  endtask

  task automatic test_boundary();
    slaveDelay = TIMEOUT; slaveData = 32'h0000_0001;
    modelResp(8'h02, TIMEOUT, 32'h0000_0001);
    runTxn(8'h02, 32'h0, 0);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord) begin
      failCount++;
      $display("FAIL boundary_resp: got %0d bytes %h required %0d bytes %h", gotCount, gotWord, expCount, expWord);
    end
  endtask

  task automatic test_back_to_back();
    slaveDelay = 0;
    modelResp(8'hFE, 0, 32'h0);
    runTxn(8'hFE, 32'hA1B2_C3D4, 0);
    testsRun++;
    if (rx_byte_ready !== 1'b1) begin
      failCount++;
      $display("FAIL back_to_back_ready: rx_byte_ready=%b required 1", rx_byte_ready);
    end
    slaveDelay = 1; slaveData = 32'h0BAD_F00D;
    modelResp(8'h7D, 1, 32'h0BAD_F00D);
    runTxn(8'h7D, 32'h0, 0);
    testsRun++;
    if (gotCount != expCount || gotWord !== expWord || lastReadAddr !== 2'd1) begin
      failCount++;
      $display("FAIL back_to_back_read: got %0d bytes %h addr %h required %0d bytes %h addr 1", gotCount, gotWord, lastReadAddr, expCount, expWord);
    end
  endtask

  task automatic test_random();
    logic [7:0]  cmd;
    logic [31:0] wdata, rdata;
    int          delay, stall, w0, r0;
    for (int n = 0; n < 24; n++) begin
      cmd = 8'($urandom_range(0, 255));
      wdata = $urandom; rdata = $urandom;
      delay = $urandom_range(1, TIMEOUT + 3);
      stall = $urandom_range(0, 3);
      slaveDelay = delay; slaveData = rdata;
      w0 = writeCount; r0 = readCount;
      modelResp(cmd, delay, rdata);
      runTxn(cmd, wdata, stall);
      testsRun++;
      if (gotCount != expCount || gotWord !== expWord) begin
        failCount++;
        $display("FAIL random_resp[%0d]: cmd %h got %0d bytes %h required %0d bytes %h", n, cmd, gotCount, gotWord, expCount, expWord);
      end
      testsRun++;
      if (cmd[7] && (writeCount - w0 != 1 || readCount != r0 || lastWriteAddr !== cmd[ADDR_W-1:0] || lastWriteData !== wdata)) begin
        failCount++;
        $display("FAIL random_write[%0d]: writes %0d addr %h data %h required 1 %h %h", n, writeCount - w0, lastWriteAddr, lastWriteData, cmd[ADDR_W-1:0], wdata);
      end else if (!cmd[7] && (readCount - r0 != 1 || writeCount != w0 || lastReadAddr !== cmd[ADDR_W-1:0])) begin
        failCount++;
        $display("FAIL random_read[%0d]: reads %0d addr %h required 1 %h", n, readCount - r0, lastReadAddr, cmd[ADDR_W-1:0]);
      end
      repeat (5) @(negedge clk);
    end
  endtask

  task automatic test_bus_protocol();
    testsRun++;
    if (bothHigh != 0 || readWide != 0 || writeWide != 0) begin
      failCount++;
      $display("FAIL bus_strobes: both=%0d read_wide=%0d write_wide=%0d required 0 0 0", bothHigh, readWide, writeWide);
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    test_write();
    test_read();
    test_timeout();
    test_backpressure();
    test_reset_mid_write();
    test_boundary();
    test_back_to_back();
    test_random();
    test_bus_protocol();
    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
